// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM pin-level responder: state encoding,
// default bus widths and the active-low control levels.
package sram_responder_pkg;

  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  localparam logic ACTIVE_N   = 1'b0;
  localparam logic INACTIVE_N = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_DRIVE  = 2'd2,
    WR_ACTIVE = 2'd3
  } state_t;

endpackage

// File: rtl/sram_array.sv
// Single-port word array: synchronous write, combinational read, same index
// for both. Contents are deliberately not reset.
module sram_array
  import sram_responder_pkg::*;
#(
  parameter int DEPTH_W = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] index,
  input  logic [DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]  rd_data
);

  logic [DATA_W-1:0] mem [2**DEPTH_W];

  always_ff @(posedge clock) begin
    if (wr_en) mem[index] <= wr_data;
  end

  assign rd_data = mem[index];

endmodule

// File: rtl/sram_responder.sv
// Chip end of the asynchronous-SRAM pin interface: decodes CE/WE/OE, commits
// writes held for WR_MIN cycles and drives read data after READ_LAT cycles.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH_W  = 4,
  parameter int READ_LAT = 2,
  parameter int WR_MIN   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chip_enable_to_chip,
  input  logic              write_enable_to_chip,
  input  logic              output_enable_to_chip,
  input  logic [ADDR_W-1:0] sram_address,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic [7:0]        write_count,
  output logic [7:0]        read_count,
  output logic              write_short,
  output logic              busy
);

  localparam int CNT_MAX = (READ_LAT > WR_MIN) ? READ_LAT : WR_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [DATA_W-1:0]   rd_data;
  logic                w, r, rd_done, wr_commit, wr_abort, drive;

  // WE overrides OE: a low WE is always a write, whatever OE says.
  assign w = (chip_enable_to_chip == ACTIVE_N) && (write_enable_to_chip == ACTIVE_N);
  assign r = (chip_enable_to_chip == ACTIVE_N) && (write_enable_to_chip == INACTIVE_N) &&
             (output_enable_to_chip == ACTIVE_N);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      write_count <= '0;
      read_count  <= '0;
      write_short <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      write_count <= write_count + 8'(wr_commit);
      read_count  <= read_count + 8'(rd_done);
      write_short <= wr_abort;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    rd_done   = 1'b0;
    wr_commit = 1'b0;
    wr_abort  = 1'b0;
    unique case (state)
      IDLE, RD_WAIT, RD_DRIVE: begin
        if (w) begin
          state_nxt = WR_ACTIVE;
          cnt_nxt   = CNT_W'(1);
          addr_nxt  = sram_address;
          data_nxt  = sram_data;
        end else if (!r) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (state == IDLE || sram_address != addr_q) begin
          // New read or address moved mid-read: latency restarts.
          state_nxt = RD_WAIT;
          cnt_nxt   = CNT_W'(1);
          addr_nxt  = sram_address;
        end else if (state == RD_WAIT) begin
          if (cnt == CNT_W'(READ_LAT)) begin
            state_nxt = RD_DRIVE;
            rd_done   = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      WR_ACTIVE: begin
        if (w) begin
          addr_nxt = sram_address;
          data_nxt = sram_data;
          if (cnt < CNT_W'(WR_MIN)) cnt_nxt = cnt + CNT_W'(1);
        end else begin
          wr_commit = (cnt >= CNT_W'(WR_MIN));
          wr_abort  = (cnt < CNT_W'(WR_MIN));
          if (r) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = CNT_W'(1);
            addr_nxt  = sram_address;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    drive = (state == RD_DRIVE);
  end

  // The commit uses the current captured index, so the array address is
  // always the captured one for both read and write.
  sram_array #(
    .DEPTH_W(DEPTH_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock  (clock),
    .wr_en  (wr_commit),
    .index  (addr_q[ADDR_W-1 -: DEPTH_W]),
    .wr_data(data_q),
    .rd_data(rd_data)
  );

  assign sram_data = drive ? rd_data : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; the data bus is pulled high so a
// released bus reads back as all ones.
module tb_sram_responder;

  localparam logic [15:0] REL = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        we = 1'b1;
  logic        oe = 1'b1;
  logic        tb_oe = 1'b0;
  logic [17:0] addr = '0;
  logic [15:0] tb_dq = '0;
  tri1  [15:0] sram_data;
  logic [7:0]  write_count, read_count;
  logic        write_short, busy;

  int checks = 0;
  int errors = 0;
  int exp_wc = 0;
  int exp_rc = 0;
  logic [15:0] exp_q[$];
  logic [17:0] last_a;
  logic [15:0] last_d;

  assign sram_data = tb_oe ? tb_dq : 'z;

  always #5 clock = ~clock;

  sram_responder dut (
    .clock                (clock),
    .reset                (reset),
    .chip_enable_to_chip  (ce),
    .write_enable_to_chip (we),
    .output_enable_to_chip(oe),
    .sram_address         (addr),
    .sram_data            (sram_data),
    .write_count          (write_count),
    .read_count           (read_count),
    .write_short          (write_short),
    .busy                 (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    ce = 1'b1; we = 1'b1; oe = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int n);
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = a; tb_dq = d; tb_oe = 1'b1;
    repeat (n) step();
    bus_idle();
    step();
    if (n >= 2) exp_wc = (exp_wc + 1) % 256;
  endtask

  task automatic do_read(input string tag, input logic [17:0] a, input logic [15:0] d);
    exp_q.push_back(d);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = a;
    step(); check({tag, "_wait1"}, sram_data, REL);
    step(); check({tag, "_wait2"}, sram_data, REL);
    step(); exp_rc = (exp_rc + 1) % 256;
    check({tag, "_data"}, sram_data, exp_q.pop_front());
    bus_idle();
    step(); check({tag, "_rel"}, sram_data, REL);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    check("rst_wc", write_count, 0);
    check("rst_rc", read_count, 0);
    check("rst_ws", write_short, 0);
    check("rst_busy", busy, 0);
    check("rst_bus", sram_data, REL);
    reset = 1'b0;
    step();

    // Seed index 3 with 0x1000
    do_write(18'h0C000, 16'h1000, 2);
    check("seed_wc", write_count, exp_wc);

    // Reset in the middle of a write: no commit, no short pulse
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 18'h0C000; tb_dq = 16'hBEEF; tb_oe = 1'b1;
    step();
    check("midwr_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midwr_rst_wc", write_count, 0);
    check("midwr_rst_busy", busy, 0);
    bus_idle();
    #1 check("midwr_rst_bus", sram_data, REL);
    exp_wc = 0;
    exp_rc = 0;
    step();
    check("midwr_ws_a", write_short, 0);
    reset = 1'b0;
    step();
    check("midwr_ws_b", write_short, 0);
    do_read("midwr_mem", 18'h0C000, 16'h1000);

    // Write then read index 0xB
    do_write(18'h2C000, 16'h5000, 2);
    check("wr_rd_wc", write_count, exp_wc);
    do_read("wr_rd", 18'h2C000, 16'h5000);
    check("wr_rd_rc", read_count, exp_rc);

    // Short write to index 3
    ce = 1'b0; we = 1'b0; oe = 1'b1; addr = 18'h0C000; tb_dq = 16'hA000; tb_oe = 1'b1;
    step();
    check("short_pre", write_short, 0);
    bus_idle();
    step();
    check("short_pulse", write_short, 1);
    step();
    check("short_end", write_short, 0);
    check("short_wc", write_count, exp_wc);
    do_read("short_mem", 18'h0C000, 16'h1000);

    // WE overrides OE while driving
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 18'h2C000;
    repeat (3) step();
    exp_rc = (exp_rc + 1) % 256;
    check("ovr_drive", sram_data, 16'h5000);
    we = 1'b0; addr = 18'h14000;
    step();
    check("ovr_rel", sram_data, REL);
    check("ovr_busy", busy, 1);
    tb_dq = 16'h7000; tb_oe = 1'b1;
    step();
    bus_idle();
    step();
    exp_wc = (exp_wc + 1) % 256;
    check("ovr_wc", write_count, exp_wc);
    do_read("ovr_mem", 18'h14000, 16'h7000);

    // Address change during a read
    do_write(18'h04000, 16'h1111, 2);
    do_write(18'h08000, 16'h2222, 2);
    ce = 1'b0; we = 1'b1; oe = 1'b0; addr = 18'h04000;
    repeat (3) step();
    exp_rc = (exp_rc + 1) % 256;
    check("ac_first", sram_data, 16'h1111);
    addr = 18'h08000;
    step(); check("ac_z1", sram_data, REL);
    step(); check("ac_z2", sram_data, REL);
    step(); exp_rc = (exp_rc + 1) % 256;
    check("ac_second", sram_data, 16'h2222);
    check("ac_rc", read_count, exp_rc);
    step(); check("ac_hold", sram_data, 16'h2222);
    bus_idle();
    step();
    check("ac_rel", sram_data, REL);
    check("ac_idle_busy", busy, 0);

    // Low address bits alias onto the same word
    do_write(18'h3FFFF, 16'h3C3C, 2);
    do_read("alias", 18'h3C000, 16'h3C3C);

    // Drive write_count round to wrap at 256
    begin
      int n;
      n = 256 - exp_wc;
      for (int i = 0; i < n; i++) begin
        last_a = 18'(i % 16) << 14;
        last_d = 16'(i * 3 + 1);
        do_write(last_a, last_d, 2);
      end
    end
    check("wrap_wc", write_count, 0);
    check("wrap_model", write_count, exp_wc);
    do_read("wrap_rd", last_a | 18'h00ABC, last_d);
    check("final_rc", read_count, exp_rc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
